// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and length-mask helper for the sequence detector
package seq_det_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_det_state_t;

    localparam int DEFAULT_PAT_W = 8;

    // Widest pattern the mask helper can describe; callers truncate to their PAT_W.
    localparam int MAX_PAT_W = 64;

    // Ones in bits [len-1:0], zeros above: selects the live part of a pattern.
    function automatic logic [MAX_PAT_W-1:0] len_mask(input int unsigned len);
        logic [MAX_PAT_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating up-counter with synchronous clear
module seq_det_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count increments, stopping at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable serial sequence detector; SEQ_DET_MATCH_CNT_EN adds match_cnt
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEFAULT_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             din_valid,
    input  logic             din,
    output logic             armed,
    output logic             match,
    output logic             cfg_err
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    seq_det_state_t   state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic [PAT_W-1:0] hist_q;
    logic [LEN_W-1:0] fill_q;
    logic             match_q;
    logic             cfg_err_q;

    logic [PAT_W-1:0] hist_d;
    logic [LEN_W-1:0] fill_d;
    logic [PAT_W-1:0] mask;
    logic             len_ok;
    logic             hit;

    // Candidate shift/fill for the current bit and the hit decision on that candidate.
    always_comb begin
        hist_d = {hist_q[PAT_W-2:0], din};
        fill_d = (fill_q == LEN_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
        mask   = PAT_W'(len_mask(32'(len_q)));
        len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
        hit    = (state_q == RUN) && din_valid && !cfg_load &&
                 (fill_d >= len_q) && (((hist_d ^ pat_q) & mask) == '0);
    end

    // Control FSM plus pattern, history and fill registers; a load always wins over data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            if (cfg_load) begin
                if (len_ok) begin
                    state_q <= RUN;
                    pat_q   <= cfg_pat;
                    len_q   <= cfg_len;
                    ovl_q   <= cfg_overlap;
                    hist_q  <= '0;
                    fill_q  <= '0;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end else if ((state_q == RUN) && din_valid) begin
                hist_q  <= hist_d;
                match_q <= hit;
                // Non-overlapping mode retires every bit that took part in the match.
                fill_q  <= (hit && !ovl_q) ? '0 : fill_d;
            end
        end
    end

    assign armed   = (state_q == RUN);
    assign match   = match_q;
    assign cfg_err = cfg_err_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    seq_det_sat_cnt #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (match_q),
        .clear (1'b0),
        .count (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pat = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_overlap = 1'b0;
    logic             din_valid = 1'b0;
    logic             din = 1'b0;
    logic             armed;
    logic             match;
    logic             cfg_err;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    seq_detector_param #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_load    (cfg_load),
        .cfg_pat     (cfg_pat),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .din_valid   (din_valid),
        .din         (din),
        .armed       (armed),
        .match       (match),
        .cfg_err     (cfg_err)
`ifdef SEQ_DET_MATCH_CNT_EN
        ,
        .match_cnt   (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk(tag, 32'(match_cnt), exp);
`else
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    task automatic bit_in(input logic v, input logic b, input logic exp_m, input string tag);
        @(negedge clk);
        cfg_load  = 1'b0;
        din_valid = v;
        din       = b;
        @(posedge clk);
        #1;
        chk(tag, 32'(match), 32'(exp_m));
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n,
                          input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            bit_in(1'b1, bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic dv, input logic d,
                        input logic exp_err, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pat     = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        din_valid   = dv;
        din         = d;
        @(posedge clk);
        #1;
        chk({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
        chk({tag, "_match"}, 32'(match), 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk_cnt("rst_cnt", 0);
        @(negedge clk);
        rstn = 1'b1;

        // Nothing loaded yet: data is ignored.
        stream(16'b1111, 16'b0000, 4, "idle");
        chk("idle_armed", 32'(armed), 32'd0);

        // Overlapping 1011.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t1_load");
        chk("t1_armed", 32'(armed), 32'd1);
        stream(16'b1011011, 16'b0001001, 7, "t1");
        bit_in(1'b0, 1'b0, 1'b0, "t1_idle");
        chk_cnt("t1_cnt", 2);

        // Non-overlapping 1011, then continued stream; counter saturates at 3.
        load(8'b0000_1011, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "t2_load");
        stream(16'b10110111011, 16'b00010000001, 11, "t2");
        bit_in(1'b0, 1'b0, 1'b0, "t2_idle");
        chk_cnt("t2_cnt", 3);

        // Length 1 with valid gaps; gap cycles carry din=1 and must not pulse.
        load(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, "t3_load");
        bit_in(1'b1, 1'b1, 1'b1, "t3_v1");
        bit_in(1'b0, 1'b1, 1'b0, "t3_g1");
        bit_in(1'b0, 1'b1, 1'b0, "t3_g2");
        bit_in(1'b1, 1'b1, 1'b1, "t3_v2");
        bit_in(1'b0, 1'b0, 1'b0, "t3_g3");
        bit_in(1'b0, 1'b0, 1'b0, "t3_g4");
        bit_in(1'b1, 1'b0, 1'b0, "t3_v3");
        bit_in(1'b0, 1'b1, 1'b0, "t3_g5");
        bit_in(1'b0, 1'b1, 1'b0, "t3_g6");
        bit_in(1'b1, 1'b1, 1'b1, "t3_v4");

        // Mid-sequence reload abandons the partial match.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t4_load");
        stream(16'b101, 16'b000, 3, "t4a");
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t4_reload");
        stream(16'b1, 16'b0, 1, "t4b");
        // Reload with a valid bit in the same cycle: that bit is discarded.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0, "t4_ldv");
        stream(16'b011011, 16'b000001, 6, "t4c");

        // Illegal lengths are rejected and the old pattern keeps working.
        load(8'b0000_0110, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, "t5_len9");
        bit_in(1'b0, 1'b0, 1'b0, "t5_gap");
        chk("t5_err_clr", 32'(cfg_err), 32'd0);
        load(8'b0000_0110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_len0");
        stream(16'b1011, 16'b0001, 4, "t5");
        chk("t5_armed", 32'(armed), 32'd1);

        // Asynchronous reset while match is high.
        load(8'b0000_1011, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, "t6_load");
        stream(16'b1011, 16'b0001, 4, "t6");
        rstn = 1'b0;
        #1;
        chk("t6_rst_armed", 32'(armed), 32'd0);
        chk("t6_rst_match", 32'(match), 32'd0);
        chk_cnt("t6_rst_cnt", 0);
        @(negedge clk);
        rstn = 1'b1;
        stream(16'b1011, 16'b0000, 4, "t6_post");
        chk("t6_post_armed", 32'(armed), 32'd0);

        // Back-to-back length-1 matches in non-overlap mode; counter holds at 3.
        load(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "t7_load");
        stream(16'b111111, 16'b111111, 6, "t7");
        bit_in(1'b0, 1'b0, 1'b0, "t7_idle");
        chk_cnt("t7_cnt", 3);
        bit_in(1'b0, 1'b0, 1'b0, "t7_hold");
        chk_cnt("t7_cnt_hold", 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
